keypad_input_conditioner: RTL and testbench
===========================================

Name: keypad_input_conditioner

Overview:
Upstream front end of the whack-a-mole core. It turns N_KEYS raw, asynchronous, bouncing mole buttons into the single-cycle user_valid pulse and user_number index that the game core consumes.
- Synchronises, debounces and validates presses.
- Rejects simultaneous multi-key presses.
- Locks out repeats until the key is released and the release is debounced.

Parameters:
N_KEYS, 16, number of buttons; user_number width NUM_W = $clog2(N_KEYS) = 4
CLOCK_FREQ, 50_000, clk frequency in Hz
DEBOUNCE_MS, 10, stability window in ms; DEBOUNCE_CYCLES = CLOCK_FREQ*DEBOUNCE_MS/1000 (500 at defaults); elaboration error if < 1

Ports:
clk  in  1  master clock
rst  in  1  asynchronous, active-high reset
btn_raw  in  N_KEYS  raw buttons, active-high, asynchronous to clk
enable  in  1  accept presses; low = presses swallowed
user_valid  out  1  one-cycle pulse: one debounced single-key press accepted
user_number  out  NUM_W  index of accepted key; valid when user_valid=1, holds last value otherwise
multi_press  out  1  one-cycle pulse: debounced press had more than one key set
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; synchroniser flops 0; state IDLE; counter 0; captured vector 0.
- Synchroniser: two flops per bit. btn_sync is the second-stage output.
- One shared counter, width $clog2(DEBOUNCE_CYCLES+1). One captured vector cap[N_KEYS-1:0].
- IDLE: if btn_sync != 0, then cap <= btn_sync, cnt <= 0, go QUALIFY.
- QUALIFY:
  - If btn_sync != cap: when btn_sync == 0, go IDLE; otherwise recapture cap <= btn_sync and set cnt <= 0 (restart).
  - Else if cnt == DEBOUNCE_CYCLES-1, go HELD and evaluate cap:
    - popcount == 1 and enable == 1: user_valid <= 1, user_number <= index of the set bit.
    - popcount > 1 and enable == 1: multi_press <= 1; user_number unchanged.
    - enable == 0: no pulse.
  - Else cnt <= cnt+1.
- HELD: if btn_sync == 0, then cnt <= 0 and go RELEASE. Keys added or removed while held are ignored.
- RELEASE:
  - btn_sync != 0: go HELD (release bounce).
  - cnt == DEBOUNCE_CYCLES-1: go IDLE.
  - Otherwise cnt <= cnt+1.
- Latency: with btn_raw stable high from clock edge k, user_valid is high for exactly the one cycle following edge k+DEBOUNCE_CYCLES+2.
- Pulses are registered and last exactly one cycle. user_valid and multi_press are never high together.
- Held key: at most one pulse per press, with no auto-repeat. A new pulse requires a debounced release first.
- enable is sampled only at the qualify-complete edge. Deasserting enable mid-QUALIFY does not abort the qualification.
- Reset asserted mid-operation: immediate return to the reset state. A key still held after reset release is treated as a fresh press and qualifies normally.

Optional Feature:
Macro: KEYPAD_PRESS_CNT_EN
- Defined: adds output press_count [15:0], reset 0.
  - Increments on every user_valid pulse.
  - Saturates at 16'hFFFF; no wrap.
  - Not incremented by multi_press or by swallowed presses.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package keypad_pkg holds:
  - state enum kp_state_t {IDLE, QUALIFY, HELD, RELEASE}
  - function clog2-safe width helper
  - function onehot_index(vector) returning NUM_W bits
  - function popcount_gt1(vector)
- Sub-module sync2 (parameterised-width two-flop synchroniser with async reset). It is natural to split it out and reuse it for other asynchronous game inputs.
- FSM, counter and encoder stay in the top module.

Test Plan:
All scenarios use CLOCK_FREQ=1000, DEBOUNCE_MS=4, so DEBOUNCE_CYCLES=4.
1. btn_raw=16'h0020 stable from edge 0, enable=1 -> user_valid high only in the cycle after edge 6, user_number=5; no further pulse while held for 50 cycles.
2. btn_raw toggles 16'h0001/0 every 2 cycles for 20 cycles, then holds 16'h0001 -> no pulse during bounce; exactly one pulse with user_number=0 after 4 stable synced cycles.
3. btn_raw=16'h0101 stable -> multi_press single pulse; user_valid stays 0; user_number keeps its previous value.
4. Press key 3, release with 2-cycle bounce, re-press key 3 after 10 low cycles -> exactly two user_valid pulses, both with user_number=3.
5. enable=0 while key 7 qualifies, then enable=1 while still held -> no pulse; after release and re-press, one pulse with user_number=7.
6. Reset asserted mid-QUALIFY while key 9 is held, then released 1 cycle later -> outputs 0 and busy=0 immediately at reset; one pulse with user_number=9 after full requalification.
   - With KEYPAD_PRESS_CNT_EN defined: press_count=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad input conditioner: FSM state
// encoding, a width helper safe for tiny values, and key-vector decoders.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    QUALIFY,
    HELD,
    RELEASE
  } kp_state_t;

  // Helpers work on a fixed maximum width; callers zero-extend and truncate.
  localparam int KP_MAX_KEYS  = 64;
  localparam int KP_MAX_NUM_W = 6;

  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // OR-encoder: exact for a one-hot input, which is the only case used.
  function automatic logic [KP_MAX_NUM_W-1:0] onehot_index(input logic [KP_MAX_KEYS-1:0] vec);
    logic [KP_MAX_NUM_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KP_MAX_KEYS; i++) begin
      if (vec[i]) idx = idx | KP_MAX_NUM_W'(i);
    end
    return idx;
  endfunction

  function automatic logic popcount_gt1(input logic [KP_MAX_KEYS-1:0] vec);
    return (vec & (vec - KP_MAX_KEYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-high reset, reusable for any
// asynchronous game input.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_input_conditioner.sv
// Keypad front end: synchronise, debounce and validate mole-button presses.
// Optional press counter output enabled by defining KEYPAD_PRESS_CNT_EN.
module keypad_input_conditioner
  import keypad_pkg::*;
#(
  parameter  int N_KEYS      = 16,
  parameter  int CLOCK_FREQ  = 50_000,
  parameter  int DEBOUNCE_MS = 10,
  localparam int NUM_W       = clog2_safe(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] btn_raw,
  input  logic              enable,
  output logic              user_valid,
  output logic [NUM_W-1:0]  user_number,
  output logic              multi_press,
  output logic              busy
`ifdef KEYPAD_PRESS_CNT_EN
  ,
  output logic [15:0]       press_count
`endif
);

  localparam int DEBOUNCE_CYCLES = CLOCK_FREQ * DEBOUNCE_MS / 1000;
  localparam int CNT_W           = clog2_safe(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("keypad_input_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end
  if (N_KEYS > KP_MAX_KEYS) begin : g_bad_keys
    $error("keypad_input_conditioner: N_KEYS exceeds KP_MAX_KEYS");
  end

  logic [N_KEYS-1:0] btn_sync;
  kp_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [N_KEYS-1:0] cap_q;
  logic              user_valid_q;
  logic              multi_press_q;
  logic [NUM_W-1:0]  user_number_q;
  logic [NUM_W-1:0]  user_number_d;
  logic              cap_multi;

  sync2 #(.WIDTH(N_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_sync)
  );

  // cap_q is never zero while qualifying, so "not more than one" means exactly one.
  assign cap_multi     = popcount_gt1(KP_MAX_KEYS'(cap_q));
  assign user_number_d = NUM_W'(onehot_index(KP_MAX_KEYS'(cap_q)));

  // NOTE: non-blocking assignments throughout so every branch reads pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: capture vector and user_number are reset too; they are tiny and
      // user_number is a visible output.
      state_q       <= IDLE;
      cnt_q         <= '0;
      cap_q         <= '0;
      user_valid_q  <= 1'b0;
      multi_press_q <= 1'b0;
      user_number_q <= '0;
    end else begin
      user_valid_q  <= 1'b0;
      multi_press_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_sync != '0) begin
            cap_q   <= btn_sync;
            cnt_q   <= '0;
            state_q <= QUALIFY;
          end
        end
        QUALIFY: begin
          if (btn_sync != cap_q) begin
            if (btn_sync == '0) begin
              state_q <= IDLE;
            end else begin
              cap_q <= btn_sync;
              cnt_q <= '0;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HELD;
            if (enable) begin
              if (cap_multi) begin
                multi_press_q <= 1'b1;
              end else begin
                user_valid_q  <= 1'b1;
                user_number_q <= user_number_d;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (btn_sync == '0) begin
            cnt_q   <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (btn_sync != '0) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign user_valid  = user_valid_q;
  assign multi_press = multi_press_q;
  assign user_number = user_number_q;
  assign busy        = (state_q != IDLE);

`ifdef KEYPAD_PRESS_CNT_EN
  logic [15:0] press_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count_q <= '0;
    end else if (user_valid_q && (press_count_q != 16'hFFFF)) begin
      press_count_q <= press_count_q + 16'd1;
    end
  end

  assign press_count = press_count_q;
`endif

endmodule

// File: tb/tb_keypad_input_conditioner.sv
// Self-checking bench for keypad_input_conditioner: directed scenarios plus
// randomized presses, compared every cycle against a run-length reference model.
module tb_keypad_input_conditioner;

  localparam int N_KEYS = 16;
  localparam int D      = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] btn_raw;
  logic        enable;
  logic        user_valid;
  logic [3:0]  user_number;
  logic        multi_press;
  logic        busy;
`ifdef KEYPAD_PRESS_CNT_EN
  logic [15:0] press_count;
`endif

  always #5 clk = ~clk;

  keypad_input_conditioner #(
    .N_KEYS      (N_KEYS),
    .CLOCK_FREQ  (1000),
    .DEBOUNCE_MS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .enable      (enable),
    .user_valid  (user_valid),
    .user_number (user_number),
    .multi_press (multi_press),
    .busy        (busy)
`ifdef KEYPAD_PRESS_CNT_EN
    ,
    .press_count (press_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_multi = 0;
  logic [3:0] last_num = '0;

  // Reference model: counts how long the synchronised vector has been stable.
  logic [15:0] m_r1, m_r2, m_prev;
  int          m_run, m_zero;
  bit          m_locked;
  bit          m_valid, m_multi, m_busy;
  logic [3:0]  m_num;
  logic [15:0] m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_prev = '0;
    m_run = 0; m_zero = 0; m_locked = 0;
    m_valid = 0; m_multi = 0; m_busy = 0;
    m_num = '0; m_count = '0;
  endtask

  task automatic model_edge();
    logic [15:0] s;
    s = m_r2;
    m_r2 = m_r1;
    m_r1 = btn_raw;
    if (m_valid && m_count != 16'hFFFF) m_count = m_count + 16'd1;
    m_valid = 0;
    m_multi = 0;
    if (!m_locked) begin
      if (s == '0)          m_run = 0;
      else if (s == m_prev) m_run = m_run + 1;
      else                  m_run = 1;
      // Accepted once the same nonzero vector was seen D+1 edges in a row.
      if (m_run == D + 1) begin
        m_locked = 1;
        m_zero   = 0;
        m_run    = 0;
        if (enable) begin
          if ($countones(s) == 1) begin
            m_valid = 1;
            for (int i = 0; i < N_KEYS; i++) if (s[i]) m_num = 4'(i);
          end else begin
            m_multi = 1;
          end
        end
      end
    end else begin
      if (s == '0) m_zero = m_zero + 1;
      else         m_zero = 0;
      if (m_zero == D + 1) begin
        m_locked = 0;
        m_zero   = 0;
      end
    end
    m_prev = s;
    m_busy = m_locked || (m_run > 0);
  endtask

  task automatic compare_all();
    check("user_valid",  32'(user_valid),  32'(m_valid));
    check("multi_press", 32'(multi_press), 32'(m_multi));
    check("user_number", 32'(user_number), 32'(m_num));
    check("busy",        32'(busy),        32'(m_busy));
`ifdef KEYPAD_PRESS_CNT_EN
    check("press_count", 32'(press_count), 32'(m_count));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    compare_all();
    if (user_valid === 1'b1) begin
      n_valid++;
      last_num = user_number;
    end
    if (multi_press === 1'b1) n_multi++;
  endtask

  task automatic release_settle();
    btn_raw = '0;
    repeat (12) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int v0, m0, first, dur, kind;
    rst = 1'b1;
    btn_raw = '0;
    enable = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) tick();
    rst = 1'b0;

    // 1: single key 5, latency and no auto-repeat while held.
    v0 = n_valid; first = -1;
    btn_raw = 16'h0020;
    for (int i = 0; i < 57; i++) begin
      tick();
      if (user_valid === 1'b1 && first < 0) first = i;
    end
    check("s1_latency", 32'(first), 32'd6);
    check("s1_pulses",  32'(n_valid - v0), 32'd1);
    check("s1_number",  32'(last_num), 32'd5);
    release_settle();

    // 2: bounce on key 0, then stable.
    v0 = n_valid;
    for (int i = 0; i < 20; i++) begin
      btn_raw = ((i / 2) % 2 == 0) ? 16'h0001 : 16'h0000;
      tick();
    end
    check("s2_bounce_quiet", 32'(n_valid - v0), 32'd0);
    btn_raw = 16'h0001;
    repeat (10) tick();
    check("s2_pulses", 32'(n_valid - v0), 32'd1);
    check("s2_number", 32'(last_num), 32'd0);
    release_settle();

    // 3: two keys together.
    v0 = n_valid; m0 = n_multi;
    btn_raw = 16'h0101;
    repeat (10) tick();
    check("s3_multi",  32'(n_multi - m0), 32'd1);
    check("s3_valid",  32'(n_valid - v0), 32'd0);
    check("s3_number", 32'(user_number), 32'd0);
    release_settle();

    // 4: key 3, bouncy release, re-press.
    v0 = n_valid;
    btn_raw = 16'h0008; repeat (10) tick();
    btn_raw = 16'h0000; repeat (2) tick();
    btn_raw = 16'h0008; repeat (2) tick();
    btn_raw = 16'h0000; repeat (10) tick();
    btn_raw = 16'h0008; repeat (10) tick();
    check("s4_pulses", 32'(n_valid - v0), 32'd2);
    check("s4_number", 32'(last_num), 32'd3);
    release_settle();

    // 5: disabled qualification swallows the press.
    v0 = n_valid;
    enable = 1'b0;
    btn_raw = 16'h0080; repeat (10) tick();
    enable = 1'b1;
    repeat (10) tick();
    check("s5_swallowed", 32'(n_valid - v0), 32'd0);
    release_settle();
    btn_raw = 16'h0080; repeat (10) tick();
    check("s5_pulses", 32'(n_valid - v0), 32'd1);
    check("s5_number", 32'(last_num), 32'd7);
    release_settle();

    // 6: reset mid-qualify with key 9 held.
    btn_raw = 16'h0200;
    repeat (4) tick();
    check("s6_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("s6_busy_reset", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    v0 = n_valid;
    repeat (12) tick();
    check("s6_pulses", 32'(n_valid - v0), 32'd1);
    check("s6_number", 32'(last_num), 32'd9);
`ifdef KEYPAD_PRESS_CNT_EN
    check("s6_press_count", 32'(press_count), 32'd1);
`endif
    release_settle();

    // Randomized segments of idle, single and multiple key presses.
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4)      btn_raw = '0;
      else if (kind < 8) btn_raw = 16'(1) << $urandom_range(0, 15);
      else               btn_raw = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      enable = ($urandom_range(0, 7) != 0);
      dur = $urandom_range(1, 12);
      repeat (dur) tick();
    end
    enable = 1'b1;
    release_settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
